// File: rtl/reg_burst_checker.sv
// 32-entry register file that also summarises each contiguous write burst (start, length, direction, stride break).
// Optional macro REG_BYPASS_EN: a same-cycle write to the read address is forwarded to o_rd_data.
module reg_burst_checker #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LEN_W = 6
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_wr_en,
    input  logic [4:0]       i_regnum,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [4:0]       i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_burst_done,
    output logic [4:0]       o_burst_start,
    output logic [LEN_W-1:0] o_burst_len,
    output logic [1:0]       o_burst_dir,
    output logic             o_burst_err,
    output logic             o_busy
);

    typedef enum logic [2:0] {
        StIdle,
        StFirst,
        StAsc,
        StDesc,
        StErr
    } state_e;

    localparam logic [LEN_W-1:0] LenMax = '1;
    localparam logic [1:0] DirSingle = 2'b00;
    localparam logic [1:0] DirAsc    = 2'b01;
    localparam logic [1:0] DirDesc   = 2'b10;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [4:0]       r_prev_reg;
    logic [4:0]       w_prev_reg_nxt;
    logic [LEN_W-1:0] r_count;
    logic [LEN_W-1:0] w_count_nxt;
    logic [4:0]       r_start;
    logic [4:0]       w_start_nxt;
    logic [1:0]       r_err_dir;
    logic [1:0]       w_err_dir_nxt;

    logic             r_done;
    logic             w_done_nxt;
    logic [4:0]       r_sum_start;
    logic [4:0]       w_sum_start_nxt;
    logic [LEN_W-1:0] r_sum_len;
    logic [LEN_W-1:0] w_sum_len_nxt;
    logic [1:0]       r_sum_dir;
    logic [1:0]       w_sum_dir_nxt;
    logic             r_sum_err;
    logic             w_sum_err_nxt;
    logic             r_busy;

    logic [WIDTH-1:0] r_mem [32];

    logic             w_step_up;
    logic             w_step_down;

    // 6-bit compare so 31 -> 0 and 0 -> 31 never look like a unit step
    assign w_step_up   = ({1'b0, i_regnum} == ({1'b0, r_prev_reg} + 6'd1));
    assign w_step_down = (({1'b0, i_regnum} + 6'd1) == {1'b0, r_prev_reg});

    always_comb begin
        w_state_nxt     = r_state;
        w_prev_reg_nxt  = r_prev_reg;
        w_count_nxt     = r_count;
        w_start_nxt     = r_start;
        w_err_dir_nxt   = r_err_dir;
        w_done_nxt      = 1'b0;
        w_sum_start_nxt = r_sum_start;
        w_sum_len_nxt   = r_sum_len;
        w_sum_dir_nxt   = r_sum_dir;
        w_sum_err_nxt   = r_sum_err;

        if (i_wr_en) begin
            w_prev_reg_nxt = i_regnum;
            w_count_nxt    = (r_count == LenMax) ? r_count : r_count + LEN_W'(1);
            case (r_state)
                StIdle: begin
                    w_state_nxt = StFirst;
                    w_start_nxt = i_regnum;
                    w_count_nxt = LEN_W'(1);
                end
                StFirst: begin
                    if (w_step_up) begin
                        w_state_nxt = StAsc;
                    end else if (w_step_down) begin
                        w_state_nxt = StDesc;
                    end else begin
                        w_state_nxt   = StErr;
                        w_err_dir_nxt = DirSingle;
                    end
                end
                StAsc: begin
                    if (!w_step_up) begin
                        w_state_nxt   = StErr;
                        w_err_dir_nxt = DirAsc;
                    end
                end
                StDesc: begin
                    if (!w_step_down) begin
                        w_state_nxt   = StErr;
                        w_err_dir_nxt = DirDesc;
                    end
                end
                StErr:   w_state_nxt = StErr;
                default: w_state_nxt = StIdle;
            endcase
        end else if (r_state != StIdle) begin
            w_state_nxt     = StIdle;
            w_done_nxt      = 1'b1;
            w_sum_start_nxt = r_start;
            w_sum_len_nxt   = r_count;
            w_sum_err_nxt   = (r_state == StErr);
            case (r_state)
                StAsc:   w_sum_dir_nxt = DirAsc;
                StDesc:  w_sum_dir_nxt = DirDesc;
                StErr:   w_sum_dir_nxt = r_err_dir;
                default: w_sum_dir_nxt = DirSingle;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= StIdle;
            r_prev_reg  <= '0;
            r_count     <= '0;
            r_start     <= '0;
            r_err_dir   <= '0;
            r_done      <= 1'b0;
            r_sum_start <= '0;
            r_sum_len   <= '0;
            r_sum_dir   <= '0;
            r_sum_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev_reg  <= w_prev_reg_nxt;
            r_count     <= w_count_nxt;
            r_start     <= w_start_nxt;
            r_err_dir   <= w_err_dir_nxt;
            r_done      <= w_done_nxt;
            r_sum_start <= w_sum_start_nxt;
            r_sum_len   <= w_sum_len_nxt;
            r_sum_dir   <= w_sum_dir_nxt;
            r_sum_err   <= w_sum_err_nxt;
            r_busy      <= (w_state_nxt != StIdle);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en && (i_regnum != 5'd0)) begin
            r_mem[i_regnum] <= i_wr_data;
        end
    end

    always_comb begin
        o_rd_data = (i_rd_addr == 5'd0) ? '0 : r_mem[i_rd_addr];
`ifdef REG_BYPASS_EN
        if (i_wr_en && (i_regnum != 5'd0) && (i_rd_addr == i_regnum)) begin
            o_rd_data = i_wr_data;
        end
`endif
    end

    assign o_burst_done  = r_done;
    assign o_burst_start = r_sum_start;
    assign o_burst_len   = r_sum_len;
    assign o_burst_dir   = r_sum_dir;
    assign o_burst_err   = r_sum_err;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_reg_burst_checker.sv
// Self-checking bench for reg_burst_checker: directed scenarios plus randomized bursts against a queue-based model.
module tb_reg_burst_checker;

    logic        i_clock;
    logic        i_reset;
    logic        i_wr_en;
    logic [4:0]  i_regnum;
    logic [31:0] i_wr_data;
    logic [4:0]  i_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_burst_done;
    logic [4:0]  o_burst_start;
    logic [5:0]  o_burst_len;
    logic [1:0]  o_burst_dir;
    logic        o_burst_err;
    logic        o_busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: memory image, current burst as a list of regnums, last summary
    logic [31:0] m_mem [32];
    logic [4:0]  m_q [$];
    logic        m_done;
    logic [4:0]  m_start;
    logic [5:0]  m_len;
    logic [1:0]  m_dir;
    logic        m_err;
    logic        m_busy;

    reg_burst_checker #(
        .WIDTH(32),
        .LEN_W(6)
    ) u_dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_wr_en      (i_wr_en),
        .i_regnum     (i_regnum),
        .i_wr_data    (i_wr_data),
        .i_rd_addr    (i_rd_addr),
        .o_rd_data    (o_rd_data),
        .o_burst_done (o_burst_done),
        .o_burst_start(o_burst_start),
        .o_burst_len  (o_burst_len),
        .o_burst_dir  (o_burst_dir),
        .o_burst_err  (o_burst_err),
        .o_busy       (o_busy)
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_q.delete();
        m_done  = 1'b0;
        m_start = '0;
        m_len   = '0;
        m_dir   = '0;
        m_err   = 1'b0;
        m_busy  = 1'b0;
    endtask

    // Summary from the whole burst: first step sets the direction, any differing step is an error
    task automatic model_summarise();
        int step;
        m_start = m_q[0];
        m_len   = (m_q.size() > 63) ? 6'd63 : 6'(m_q.size());
        m_dir   = 2'b00;
        m_err   = 1'b0;
        if (m_q.size() > 1) begin
            step = int'(m_q[1]) - int'(m_q[0]);
            if (step == 1) m_dir = 2'b01;
            else if (step == -1) m_dir = 2'b10;
            else m_err = 1'b1;
            for (int i = 2; i < m_q.size(); i++) begin
                if (int'(m_q[i]) - int'(m_q[i-1]) != step) m_err = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] model_read(input logic we, input logic [4:0] rn,
                                               input logic [31:0] d, input logic [4:0] ra);
        if (ra == 5'd0) return 32'h0;
`ifdef REG_BYPASS_EN
        if (we && rn != 5'd0 && ra == rn) return d;
`endif
        return m_mem[ra];
    endfunction

    // Called just after a falling edge; returns just after the next falling edge
    task automatic drive(input logic we, input logic [4:0] rn, input logic [31:0] d,
                         input logic [4:0] ra);
        i_wr_en   = we;
        i_regnum  = rn;
        i_wr_data = d;
        i_rd_addr = ra;
        @(posedge i_clock);
        if (we) begin
            if (rn != 5'd0) m_mem[rn] = d;
            m_q.push_back(rn);
            m_done = 1'b0;
        end else if (m_q.size() > 0) begin
            model_summarise();
            m_q.delete();
            m_done = 1'b1;
        end else begin
            m_done = 1'b0;
        end
        m_busy = (m_q.size() > 0);
        @(negedge i_clock);
    endtask

    task automatic test_reset();
        i_reset   = 1'b0;
        i_wr_en   = 1'b0;
        i_regnum  = '0;
        i_wr_data = '0;
        i_rd_addr = 5'd8;
        model_reset();
        repeat (2) @(negedge i_clock);
        n_checks++;
        if (o_burst_done !== 1'b0 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: done=%b busy=%b, required 0 0", o_burst_done, o_busy);
        end
        n_checks++;
        if (o_burst_start !== 5'd0 || o_burst_len !== 6'd0 || o_burst_dir !== 2'd0
            || o_burst_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_summary: start=%0d len=%0d dir=%b err=%b, required all 0",
                     o_burst_start, o_burst_len, o_burst_dir, o_burst_err);
        end
        n_checks++;
        if (o_rd_data !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_read: rd_data=%h, required 0", o_rd_data);
        end
        i_reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd0);
    endtask

    task automatic test_ascending();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 5'(8 + k), 32'h11 + k, 5'd10);
            n_checks++;
            if (o_busy !== 1'b1 || o_burst_done !== 1'b0) begin
                n_errors++;
                $display("FAIL asc_busy[%0d]: busy=%b done=%b, required 1 0", k, o_busy,
                         o_burst_done);
            end
        end
        drive(1'b0, 5'd0, 32'h0, 5'd10);
        n_checks++;
        if (o_burst_done !== 1'b1 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL asc_done: done=%b busy=%b, required 1 0", o_burst_done, o_busy);
        end
        n_checks++;
        if (o_burst_start !== 5'd8 || o_burst_len !== 6'd5 || o_burst_dir !== 2'b01
            || o_burst_err !== 1'b0) begin
            n_errors++;
            $display("FAIL asc_summary: start=%0d len=%0d dir=%b err=%b, required 8 5 01 0",
                     o_burst_start, o_burst_len, o_burst_dir, o_burst_err);
        end
        n_checks++;
        if (o_rd_data !== 32'h13) begin
            n_errors++;
            $display("FAIL asc_read10: rd_data=%h, required 00000013", o_rd_data);
        end
        drive(1'b0, 5'd0, 32'h0, 5'd12);
        n_checks++;
        if (o_burst_done !== 1'b0 || o_burst_len !== 6'd5 || o_rd_data !== 32'h15) begin
            n_errors++;
            $display("FAIL asc_hold: done=%b len=%0d rd12=%h, required 0 5 00000015",
                     o_burst_done, o_burst_len, o_rd_data);
        end
    endtask

    task automatic test_descending();
        int busy_cycles = 0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 5'(8 - k), 32'h20 + k, 5'd0);
            if (o_busy === 1'b1) busy_cycles++;
        end
        drive(1'b0, 5'd0, 32'h0, 5'd0);
        if (o_busy === 1'b1) busy_cycles++;
        n_checks++;
        if (busy_cycles != 5) begin
            n_errors++;
            $display("FAIL desc_busy_cycles: busy high %0d cycles, required 5", busy_cycles);
        end
        n_checks++;
        if (o_burst_done !== 1'b1 || o_burst_start !== 5'd8 || o_burst_len !== 6'd5
            || o_burst_dir !== 2'b10 || o_burst_err !== 1'b0) begin
            n_errors++;
            $display("FAIL desc_summary: done=%b start=%0d len=%0d dir=%b err=%b, req 1 8 5 10 0",
                     o_burst_done, o_burst_start, o_burst_len, o_burst_dir, o_burst_err);
        end
    endtask

    task automatic test_stride_break();
        logic [4:0] seq [4];
        seq[0] = 5'd8; seq[1] = 5'd9; seq[2] = 5'd11; seq[3] = 5'd12;
        for (int k = 0; k < 4; k++) drive(1'b1, seq[k], 32'h30 + k, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 5'd0);
        n_checks++;
        if (o_burst_done !== 1'b1 || o_burst_len !== 6'd4 || o_burst_dir !== 2'b01
            || o_burst_err !== 1'b1) begin
            n_errors++;
            $display("FAIL break_asc: done=%b len=%0d dir=%b err=%b, required 1 4 01 1",
                     o_burst_done, o_burst_len, o_burst_dir, o_burst_err);
        end
        drive(1'b1, 5'd31, 32'h3F, 5'd0);
        drive(1'b1, 5'd0, 32'h40, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 5'd31);
        n_checks++;
        if (o_burst_done !== 1'b1 || o_burst_start !== 5'd31 || o_burst_len !== 6'd2
            || o_burst_dir !== 2'b00 || o_burst_err !== 1'b1) begin
            n_errors++;
            $display("FAIL break_wrap: done=%b start=%0d len=%0d dir=%b err=%b, req 1 31 2 00 1",
                     o_burst_done, o_burst_start, o_burst_len, o_burst_dir, o_burst_err);
        end
        n_checks++;
        if (o_rd_data !== 32'h3F) begin
            n_errors++;
            $display("FAIL break_read31: rd_data=%h, required 0000003f", o_rd_data);
        end
    endtask

    task automatic test_reg_zero();
        drive(1'b1, 5'd0, 32'hDEAD, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 5'd0);
        n_checks++;
        if (o_rd_data !== 32'h0) begin
            n_errors++;
            $display("FAIL zero_read: rd_data=%h, required 0", o_rd_data);
        end
        n_checks++;
        if (o_burst_done !== 1'b1 || o_burst_start !== 5'd0 || o_burst_len !== 6'd1
            || o_burst_dir !== 2'b00 || o_burst_err !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_summary: done=%b start=%0d len=%0d dir=%b err=%b, req 1 0 1 00 0",
                     o_burst_done, o_burst_start, o_burst_len, o_burst_dir, o_burst_err);
        end
    endtask

    task automatic test_reset_mid_burst();
        int dones = 0;
        drive(1'b1, 5'd8, 32'hAA, 5'd8);
        drive(1'b1, 5'd9, 32'hBB, 5'd8);
        i_wr_en = 1'b0;
        #2 i_reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (o_burst_done !== 1'b0 || o_busy !== 1'b0 || o_burst_start !== 5'd0
            || o_burst_len !== 6'd0 || o_burst_dir !== 2'd0 || o_burst_err !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_async: done=%b busy=%b start=%0d len=%0d dir=%b err=%b, req 0",
                     o_burst_done, o_busy, o_burst_start, o_burst_len, o_burst_dir, o_burst_err);
        end
        n_checks++;
        if (o_rd_data !== 32'h0) begin
            n_errors++;
            $display("FAIL midrst_read8: rd_data=%h, required 0", o_rd_data);
        end
        @(negedge i_clock);
        i_reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 5'd0, 32'h0, 5'd9);
            if (o_burst_done !== 1'b0) dones++;
        end
        n_checks++;
        if (dones != 0 || o_rd_data !== 32'h0) begin
            n_errors++;
            $display("FAIL midrst_after: done pulses=%0d rd9=%h, required 0 0", dones, o_rd_data);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] want;
        i_wr_en   = 1'b1;
        i_regnum  = 5'd5;
        i_wr_data = 32'h77;
        i_rd_addr = 5'd5;
`ifdef REG_BYPASS_EN
        want = 32'h77;
`else
        want = 32'h0;
`endif
        #1;
        n_checks++;
        if (o_rd_data !== want) begin
            n_errors++;
            $display("FAIL bypass_same_cycle: rd_data=%h, required %h", o_rd_data, want);
        end
        drive(1'b1, 5'd5, 32'h77, 5'd5);
        i_wr_en = 1'b0;
        #1;
        n_checks++;
        if (o_rd_data !== 32'h77) begin
            n_errors++;
            $display("FAIL bypass_next_cycle: rd_data=%h, required 00000077", o_rd_data);
        end
        drive(1'b0, 5'd0, 32'h0, 5'd5);
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 70; k++) drive(1'b1, 5'(k), $urandom, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 5'd0);
        n_checks++;
        if (o_burst_done !== 1'b1 || o_burst_len !== 6'd63 || o_burst_err !== 1'b1
            || o_burst_dir !== 2'b01) begin
            n_errors++;
            $display("FAIL saturation: done=%b len=%0d dir=%b err=%b, required 1 63 01 1",
                     o_burst_done, o_burst_len, o_burst_dir, o_burst_err);
        end
    endtask

    task automatic test_random();
        logic [4:0]  r;
        logic [4:0]  ra;
        logic [31:0] d;
        logic [31:0] want;
        int          len;
        int          mode;
        for (int b = 0; b < 60; b++) begin
            len  = $urandom_range(1, 8);
            mode = $urandom_range(0, 2);
            r    = 5'($urandom_range(0, 31));
            for (int j = 0; j < len; j++) begin
                d  = $urandom;
                ra = ($urandom_range(0, 3) == 0) ? r : 5'($urandom_range(0, 31));
                i_wr_en = 1'b1; i_regnum = r; i_wr_data = d; i_rd_addr = ra;
                #1;
                want = model_read(1'b1, r, d, ra);
                n_checks++;
                if (o_rd_data !== want) begin
                    n_errors++;
                    $display("FAIL rand_read b%0d: addr=%0d rd_data=%h, required %h", b, ra,
                             o_rd_data, want);
                end
                drive(1'b1, r, d, ra);
                n_checks++;
                if (o_busy !== m_busy || o_burst_done !== m_done) begin
                    n_errors++;
                    $display("FAIL rand_wr b%0d: busy=%b done=%b, required %b %b", b, o_busy,
                             o_burst_done, m_busy, m_done);
                end
                if ($urandom_range(0, 9) == 0) r = 5'($urandom_range(0, 31));
                else if (mode == 0) r = r + 5'd1;
                else if (mode == 1) r = r - 5'd1;
                else r = 5'($urandom_range(0, 31));
            end
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                drive(1'b0, 5'd0, 32'h0, 5'($urandom_range(0, 31)));
                n_checks++;
                if (o_burst_done !== m_done || o_busy !== m_busy || o_burst_start !== m_start
                    || o_burst_len !== m_len || o_burst_dir !== m_dir || o_burst_err !== m_err
                    || o_rd_data !== model_read(1'b0, 5'd0, 32'h0, i_rd_addr)) begin
                    n_errors++;
                    $display("FAIL rand_sum b%0d: done=%b busy=%b start=%0d len=%0d dir=%b err=%b rd=%h, required %b %b %0d %0d %b %b %h",
                             b, o_burst_done, o_busy, o_burst_start, o_burst_len, o_burst_dir,
                             o_burst_err, o_rd_data, m_done, m_busy, m_start, m_len, m_dir,
                             m_err, model_read(1'b0, 5'd0, 32'h0, i_rd_addr));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_descending();
        test_stride_break();
        test_reg_zero();
        test_reset_mid_burst();
        test_bypass();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
